// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_queue
//  Purpose  : Instruction fetch front end. Issues one-cycle-latency reads to
//             instruction memory under a credit rule and buffers responses
//             in a 2-entry {pc, instr} FIFO for the decode stage. Redirects
//             flush the FIFO and restart fetch at the new target.
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch PC and the single outstanding request
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] tag_q, tag_d;
  logic        kill_q, kill_d;

  // Two-entry FIFO: head is always entry 0, so no pointers are needed
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;

  logic        pop;
  logic        push;
  logic [2:0]  occ;
  logic [1:0]  cnt_after_pop;

  // Credit check, request generation and FIFO/PC next-state
  always_comb begin
    if_valid      = (count_q != 2'd0) & ~rst;
    pop           = if_valid & id_ready;
    push          = inflight_q & ~kill_q;
    occ           = {1'b0, count_q} + {2'b00, inflight_q};
    // A same-cycle pop frees a slot, so it raises the credit limit by one
    imem_req      = ~rst & ~redirect_valid & (occ < (3'd2 + {2'b00, pop}));
    imem_addr     = pc_q;

    if_instr      = if_valid ? head_instr_q : NOP_INSTR;
    if_pc         = if_valid ? head_pc_q    : 32'h0000_0000;

    pc_d          = imem_req ? (pc_q + 32'd4) : pc_q;
    inflight_d    = imem_req;
    tag_d         = imem_req ? pc_q : tag_q;
    kill_d        = redirect_valid;

    // Pop first (shift tail into head), then append the response
    head_pc_d     = pop ? tail_pc_q    : head_pc_q;
    head_instr_d  = pop ? tail_instr_q : head_instr_q;
    tail_pc_d     = tail_pc_q;
    tail_instr_d  = tail_instr_q;
    cnt_after_pop = count_q - {1'b0, pop};
    count_d       = cnt_after_pop + {1'b0, push};
    if (push) begin
      if (cnt_after_pop == 2'd0) begin
        head_pc_d    = tag_q;
        head_instr_d = imem_rdata;
      end else begin
        tail_pc_d    = tag_q;
        tail_instr_d = imem_rdata;
      end
    end

    // Redirect drops everything buffered, including a response landing now
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = {redirect_pc[31:2], 2'b00};
    end
  end

  // State registers; reset clears control state, data entries need no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
    end
    tag_q        <= tag_d;
    head_pc_q    <= head_pc_d;
    head_instr_q <= head_instr_d;
    tail_pc_q    <= tail_pc_d;
    tail_instr_q <= tail_instr_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_queue
//  Purpose  : Self-checking bench for ifetch_queue with a delivery scoreboard
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ifetch_queue #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  // Memory: one-cycle read latency, garbage when no request was made
  always @(posedge clk)
    imem_rdata <= imem_req ? (imem_addr ^ XOR_KEY) : $urandom;

  // Scoreboard: every accepted instruction must be the next expected one
  always @(negedge clk) begin
    if (if_valid === 1'b1 && id_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required none", if_pc, if_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          errors++;
          $display("FAIL sb_order: got pc=%h instr=%h, required pc=%h instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
    end else if (if_valid === 1'b0) begin
      checks++;
      if (if_instr !== NOP || if_pc !== 32'h0) begin
        errors++;
        $display("FAIL idle_nop: got pc=%h instr=%h, required pc=0 instr=%h",
                 if_pc, if_instr, NOP);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    exp_t        e;
    logic [31:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      e.pc    = p;
      e.instr = p ^ XOR_KEY;
      exp_q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", if_valid); end
    checks++; if (if_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h, required %h", if_instr, NOP); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h, required 0", if_pc); end
  endtask

  task automatic test_cold_start();
    tick();
    rst = 1'b0;
    exp_q.delete();
    push_seq(RESET_PC, 24);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL cold_req0: got req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL cold_c1_valid: got %b, required 0", if_valid); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hA5A5_0000) begin errors++; $display("FAIL cold_c2: got v=%b pc=%h instr=%h, required 1 0 a5a50000", if_valid, if_pc, if_instr); end
    for (int k = 1; k <= 3; k++) begin
      tick(); @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k)) begin errors++; $display("FAIL cold_stream: got v=%b pc=%h, required 1 %h", if_valid, if_pc, 32'(4 * k)); end
    end
    tick();
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    tick();
    rst = 1'b1;
    id_ready = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    push_seq(RESET_PC, 24);
    tick();
    tick();
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hA5A5_0000) begin errors++; $display("FAIL bp_hold: got v=%b pc=%h instr=%h, required 1 0 a5a50000", if_valid, if_pc, if_instr); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_noreq: got %b, required 0", imem_req); end
      tick();
    end
    id_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume_req: got req=%b addr=%h, required 1 8", imem_req, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k)) begin errors++; $display("FAIL bp_drain: got v=%b pc=%h, required 1 %h", if_valid, if_pc, 32'(4 * k)); end
      tick(); @(negedge clk);
    end
    tick();
    id_ready = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_redirect_full();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdf_req: got %b, required 0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    exp_q.delete();
    push_seq(32'h100, 24);
    id_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rdf_flush: got %b, required 0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdf_target: got req=%b addr=%h, required 1 100", imem_req, imem_addr); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rdf_gap: got %b, required 0", if_valid); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("FAIL rdf_first: got v=%b pc=%h, required 1 100", if_valid, if_pc); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin errors++; $display("FAIL rdf_second: got v=%b pc=%h, required 1 104", if_valid, if_pc); end
    tick();
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req_a: got %b, required 0", imem_req); end
    tick();
    redirect_pc = 32'h300;
    exp_q.delete();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL b2b_second: got req=%b v=%b, required 0 0", imem_req, if_valid); end
    tick();
    redirect_valid = 1'b0;
    exp_q.delete();
    push_seq(32'h300, 24);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL b2b_target: got req=%b addr=%h, required 1 300", imem_req, imem_addr); end
    tick(); tick(); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300 + 32'(4 * k)) begin errors++; $display("FAIL b2b_stream: got v=%b pc=%h, required 1 %h", if_valid, if_pc, 32'h300 + 32'(4 * k)); end
      tick(); @(negedge clk);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    exp_q.delete();
    push_seq(32'hFFFF_FFF8, 16);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_req: got req=%b addr=%h, required 1 fffffff8", imem_req, imem_addr); end
    tick(); tick(); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (if_valid !== 1'b1 || if_pc !== want[k]) begin errors++; $display("FAIL wrap_stream: got v=%b pc=%h, required 1 %h", if_valid, if_pc, want[k]); end
      tick(); @(negedge clk);
    end
    tick();
    id_ready = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL rstm_pre: got %b, required 1", if_valid); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin errors++; $display("FAIL rstm_out: got v=%b pc=%h instr=%h, required 0 0 %h", if_valid, if_pc, if_instr, NOP); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rstm_req: got %b, required 0", imem_req); end
    tick();
    rst = 1'b0;
    id_ready = 1'b1;
    exp_q.delete();
    push_seq(RESET_PC, 16);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL rstm_req0: got req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rstm_c1: got %b, required 0", if_valid); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hA5A5_0000) begin errors++; $display("FAIL rstm_c2: got v=%b pc=%h instr=%h, required 1 0 a5a50000", if_valid, if_pc, if_instr); end
    tick(); @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin errors++; $display("FAIL rstm_c3: got v=%b pc=%h, required 1 4", if_valid, if_pc); end
    tick();
    id_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_backpressure();
    test_redirect_full();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
